// File: rtl/id_stage_reg.sv
`default_nettype none
// id_stage_reg: ID/EX pipeline register with flush/freeze/bubble control
// Revision 1.0 - initial release
module id_stage_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        freeze,
  input  logic        bubble,
  input  logic        valid_in,
  input  logic [31:0] PC_in,
  input  logic [3:0]  EX_command_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        WB_en_in,
  input  logic        B_in,
  input  logic        S_in,
  input  logic        Imm_in,
  input  logic [31:0] val_Rn_in,
  input  logic [31:0] val_Rm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  input  logic        C_in,
  output logic [31:0] PC,
  output logic [3:0]  EX_command,
  output logic        mem_read,
  output logic        mem_write,
  output logic        WB_en,
  output logic        B,
  output logic        S,
  output logic        Imm,
  output logic [31:0] val_Rn,
  output logic [31:0] val_Rm,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm_24,
  output logic [3:0]  dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        C,
  output logic        valid,
  output logic [15:0] bubble_count
);

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC            <= '0;
      EX_command    <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      WB_en         <= 1'b0;
      B             <= 1'b0;
      S             <= 1'b0;
      Imm           <= 1'b0;
      val_Rn        <= '0;
      val_Rm        <= '0;
      shift_operand <= '0;
      signed_imm_24 <= '0;
      dest          <= '0;
      src1          <= '0;
      src2          <= '0;
      C             <= 1'b0;
      valid         <= 1'b0;
      bubble_count  <= '0;
    end else if (flush) begin
      // Killed instruction: everything clears, the bubble statistic survives
      PC            <= '0;
      EX_command    <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      WB_en         <= 1'b0;
      B             <= 1'b0;
      S             <= 1'b0;
      Imm           <= 1'b0;
      val_Rn        <= '0;
      val_Rm        <= '0;
      shift_operand <= '0;
      signed_imm_24 <= '0;
      dest          <= '0;
      src1          <= '0;
      src2          <= '0;
      C             <= 1'b0;
      valid         <= 1'b0;
    end else if (!freeze) begin
      PC            <= PC_in;
      Imm           <= Imm_in;
      val_Rn        <= val_Rn_in;
      val_Rm        <= val_Rm_in;
      shift_operand <= shift_operand_in;
      signed_imm_24 <= signed_imm_24_in;
      dest          <= dest_in;
      src1          <= src1_in;
      src2          <= src2_in;
      C             <= C_in;
      if (bubble) begin
        // Datapath still flows; only side-effecting control is suppressed
        EX_command <= '0;
        mem_read   <= 1'b0;
        mem_write  <= 1'b0;
        WB_en      <= 1'b0;
        B          <= 1'b0;
        S          <= 1'b0;
        valid      <= 1'b0;
        if (bubble_count != COUNT_MAX)
          bubble_count <= bubble_count + 16'd1;
      end else begin
        EX_command <= EX_command_in;
        mem_read   <= mem_read_in  & valid_in;
        mem_write  <= mem_write_in & valid_in;
        WB_en      <= WB_en_in     & valid_in;
        B          <= B_in         & valid_in;
        S          <= S_in         & valid_in;
        valid      <= valid_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/id_stage_reg.md
ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 flush  input  1  taken branch in EX; kill the instruction being captured.
REQ-005 freeze  input  1  downstream stall; hold all outputs.
REQ-006 bubble  input  1  hazard unit request; insert a NOP instead of capturing.
REQ-007 valid_in  input  1  the ID-stage instruction is real, not a NOP.
REQ-008 PC_in / PC  input / output  32  instruction PC+4.
REQ-009 EX_command_in / EX_command  input / output  4  ALU command from the control unit.
REQ-010 mem_read_in, mem_write_in, WB_en_in, B_in, S_in / same names without _in  input / output  1 each  control-unit control bits; S is the status update enable.
REQ-011 Imm_in / Imm  input / output  1  immediate operand select.
REQ-012 val_Rn_in, val_Rm_in / val_Rn, val_Rm  input / output  32 each  register-file read data.
REQ-013 shift_operand_in / shift_operand  input / output  12  operand-2 field.
REQ-014 signed_imm_24_in / signed_imm_24  input / output  24  branch offset.
REQ-015 dest_in, src1_in, src2_in / dest, src1, src2  input / output  4 each  register numbers.
REQ-016 C_in / C  input / output  1  carry flag sampled in ID.
REQ-017 valid  output  1  registered instruction valid.
REQ-018 bubble_count  output  16  saturating count of inserted bubbles.

Function
REQ-019 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-020 At each rising clk edge the block SHALL apply exactly one action, in priority order: flush > freeze > bubble > load.
REQ-021 Flush SHALL clear every output to 0 except bubble_count, whether or not freeze is asserted.
REQ-022 Freeze SHALL hold every output, including bubble_count, at its current value.
REQ-023 Bubble SHALL:
  - clear mem_read, mem_write, WB_en, B, S and valid;
  - set EX_command to 0;
  - capture the datapath fields (PC, val_Rn, val_Rm, shift_operand, signed_imm_24, dest, src1, src2, Imm, C) normally;
  - increment bubble_count by 1.
REQ-024 Load SHALL capture every *_in input into its output and set valid = valid_in.
REQ-025 When valid_in = 0 on a load, the block SHALL force mem_read, mem_write, WB_en, B and S to 0.
REQ-026 bubble_count SHALL saturate at 0xFFFF and never wrap.
REQ-027 Flush SHALL NOT increment bubble_count.
REQ-028 Latency SHALL be exactly 1 cycle from inputs to outputs on a load.
REQ-029 A held (frozen) instruction SHALL remain frozen until freeze deasserts, and SHALL then take the highest-priority action present at that edge.
REQ-030 A flush that coincides with bubble SHALL produce the flush result only.

Reset
REQ-031 rst high SHALL immediately, independent of clk, drive every output including bubble_count to 0.
REQ-032 While rst is high, clock edges SHALL have no effect.
REQ-033 After rst falls, the first rising edge SHALL perform the normal priority action.
REQ-034 rst asserted mid-freeze or mid-bubble sequence SHALL discard all held state.

Verification
REQ-035 Load with PC_in=0x00000010, EX_command_in=0x2, WB_en_in=1, valid_in=1, val_Rn_in=0xDEADBEEF -> next cycle PC=0x10, EX_command=0x2, WB_en=1, valid=1, val_Rn=0xDEADBEEF.
REQ-036 Load a STR (mem_write_in=1), then assert freeze for 3 cycles with changed inputs -> outputs are unchanged for 3 cycles; the first edge after freeze drops loads the new inputs.
REQ-037 flush=1 together with freeze=1 and bubble=1 -> next cycle all outputs are 0, valid=0 and bubble_count is unchanged.
REQ-038 Bubble with mem_read_in=1, dest_in=0x5 -> mem_read=0, WB_en=0, valid=0, dest=0x5, bubble_count +1; from bubble_count=0xFFFF one more bubble -> still 0xFFFF.
REQ-039 Assert rst asynchronously between edges while valid=1 and bubble_count=7 -> outputs go to 0 before the next edge; outputs stay 0 until the first edge after rst release.
